// File: rtl/uc_if.sv
// rtl/uc_if.sv - decode bus between instruction fields and the uc control outputs
interface uc_if;
    logic [6:0] op;
    logic [2:0] func3;
    logic       func7;
    logic       zero;
    logic       pcSrc;
    logic       branch;
    logic       resSrc;
    logic       memWrite;
    logic       aluSrc;
    logic       regWrite;
    logic [2:0] aluControl;
    logic [1:0] immSrc;
    logic       illegalOp;

    modport master (
        output op, func3, func7, zero,
        input  pcSrc, branch, resSrc, memWrite, aluSrc, regWrite,
               aluControl, immSrc, illegalOp
    );

    modport slave (
        input  op, func3, func7, zero,
        output pcSrc, branch, resSrc, memWrite, aluSrc, regWrite,
               aluControl, immSrc, illegalOp
    );
endinterface

// File: rtl/uc.sv
// rtl/uc.sv - single-cycle RV32I control unit with sticky illegal-opcode flag (option: UC_ILLEGAL_GATE_EN)
module uc (
    input  logic clk,
    input  logic reset,
    uc_if.slave  bus
);

    logic       reg_write;
    logic       mem_write;
    logic       legal;
    logic       dec_branch;
    logic [1:0] alu_op;
    logic       illegal_q;
    logic       gate;

    // Main decoder: opcode to datapath selects; unknown opcodes drive all zeros.
    always_comb begin
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        bus.immSrc  = 2'b00;
        bus.aluSrc  = 1'b0;
        bus.resSrc  = 1'b0;
        dec_branch  = 1'b0;
        alu_op      = 2'b00;
        legal       = 1'b1;
        case (bus.op)
            7'b0000011: begin
                reg_write  = 1'b1;
                bus.aluSrc = 1'b1;
                bus.resSrc = 1'b1;
            end
            7'b0100011: begin
                bus.immSrc = 2'b01;
                bus.aluSrc = 1'b1;
                mem_write  = 1'b1;
            end
            7'b0110011: begin
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            7'b1100011: begin
                bus.immSrc = 2'b10;
                dec_branch = 1'b1;
                alu_op     = 2'b01;
            end
            7'b0010011: begin
                reg_write  = 1'b1;
                bus.aluSrc = 1'b1;
                alu_op     = 2'b10;
            end
            default: legal = 1'b0;
        endcase
    end

    // ALU decoder: only R-type (op[5]=1) with func7 set turns add into sub.
    always_comb begin
        bus.aluControl = 3'b000;
        case (alu_op)
            2'b01: bus.aluControl = 3'b001;
            2'b10: begin
                case (bus.func3)
                    3'b000:  bus.aluControl = (bus.op[5] && bus.func7) ? 3'b001 : 3'b000;
                    3'b010:  bus.aluControl = 3'b101;
                    3'b110:  bus.aluControl = 3'b011;
                    3'b111:  bus.aluControl = 3'b010;
                    default: bus.aluControl = 3'b000;
                endcase
            end
            default: bus.aluControl = 3'b000;
        endcase
    end

    // Sticky illegal-opcode flag; reset wins over a simultaneous set.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (!legal) begin
            illegal_q <= 1'b1;
        end
    end

`ifdef UC_ILLEGAL_GATE_EN
    assign gate = !legal || illegal_q;
`else
    assign gate = 1'b0;
`endif

    // Side-effecting strobes, optionally suppressed after a bad fetch.
    always_comb begin
        bus.branch    = dec_branch;
        bus.regWrite  = reg_write && !gate;
        bus.memWrite  = mem_write && !gate;
        bus.pcSrc     = dec_branch && bus.zero && !gate;
        bus.illegalOp = illegal_q;
    end

endmodule

// File: tb/tb_uc.sv
// tb/tb_uc.sv - scoreboard bench for uc with directed decode vectors
module tb_uc;

    logic clk;
    logic reset;
    uc_if bus ();

    uc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [11:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    bit   stim_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word: {pcSrc, branch, resSrc, memWrite, aluSrc, regWrite, aluControl, immSrc, illegalOp}
    task automatic apply(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic z, input logic rst,
                         input logic pc, input logic br, input logic rs, input logic mw,
                         input logic as, input logic rw, input logic [2:0] alu,
                         input logic [1:0] imm, input logic ill);
        exp_t e;
        @(posedge clk);
        #1;
        bus.op    = op;
        bus.func3 = f3;
        bus.func7 = f7;
        bus.zero  = z;
        reset     = rst;
`ifdef UC_ILLEGAL_GATE_EN
        if (ill) begin
            pc = 1'b0;
            mw = 1'b0;
            rw = 1'b0;
        end
`endif
        e.v    = {pc, br, rs, mw, as, rw, alu, imm, ill};
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per cycle, mid-cycle away from the clock edge.
    initial begin
        exp_t        e;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.pcSrc, bus.branch, bus.resSrc, bus.memWrite, bus.aluSrc,
                       bus.regWrite, bus.aluControl, bus.immSrc, bus.illegalOp};
                n_cmp++;
                if (act !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %b expected %b", e.name, act, e.v);
                end
            end
        end
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        stim_done = 1'b0;
        reset     = 1'b1;
        bus.op    = 7'b0000011;
        bus.func3 = 3'b000;
        bus.func7 = 1'b0;
        bus.zero  = 1'b0;
        repeat (2) @(posedge clk);

        //     name            op          f3      f7  z   rst  pc  br  rs  mw  as  rw  alu     imm    ill
        apply("reset_lw",      7'b0000011, 3'b000, 0, 0, 0,   0,  0,  1,  0,  1,  1, 3'b000, 2'b00, 0);
        apply("sw",            7'b0100011, 3'b010, 0, 0, 0,   0,  0,  0,  1,  1,  0, 3'b000, 2'b01, 0);
        apply("beq_taken",     7'b1100011, 3'b000, 0, 1, 0,   1,  1,  0,  0,  0,  0, 3'b001, 2'b10, 0);
        apply("beq_not_taken", 7'b1100011, 3'b000, 0, 0, 0,   0,  1,  0,  0,  0,  0, 3'b001, 2'b10, 0);
        apply("r_add",         7'b0110011, 3'b000, 0, 0, 0,   0,  0,  0,  0,  0,  1, 3'b000, 2'b00, 0);
        apply("r_sub",         7'b0110011, 3'b000, 1, 0, 0,   0,  0,  0,  0,  0,  1, 3'b001, 2'b00, 0);
        apply("r_and",         7'b0110011, 3'b111, 0, 0, 0,   0,  0,  0,  0,  0,  1, 3'b010, 2'b00, 0);
        apply("r_or",          7'b0110011, 3'b110, 0, 0, 0,   0,  0,  0,  0,  0,  1, 3'b011, 2'b00, 0);
        apply("addi_f7",       7'b0010011, 3'b000, 1, 0, 0,   0,  0,  0,  0,  1,  1, 3'b000, 2'b00, 0);
        apply("r_slt",         7'b0110011, 3'b010, 0, 0, 0,   0,  0,  0,  0,  0,  1, 3'b101, 2'b00, 0);
        apply("slti",          7'b0010011, 3'b010, 0, 0, 0,   0,  0,  0,  0,  1,  1, 3'b101, 2'b00, 0);
        apply("r_f3_001",      7'b0110011, 3'b001, 1, 0, 0,   0,  0,  0,  0,  0,  1, 3'b000, 2'b00, 0);
        apply("lw_zero1",      7'b0000011, 3'b010, 0, 1, 0,   0,  0,  1,  0,  1,  1, 3'b000, 2'b00, 0);
        apply("illegal_rst",   7'b1111111, 3'b111, 1, 1, 1,   0,  0,  0,  0,  0,  0, 3'b000, 2'b00, 0);
        apply("rst_priority",  7'b0000011, 3'b000, 0, 0, 0,   0,  0,  1,  0,  1,  1, 3'b000, 2'b00, 0);
        apply("illegal_op",    7'b1111111, 3'b000, 0, 1, 0,   0,  0,  0,  0,  0,  0, 3'b000, 2'b00, 0);
        apply("sticky_lw",     7'b0000011, 3'b000, 0, 0, 0,   0,  0,  1,  0,  1,  1, 3'b000, 2'b00, 1);
        apply("sticky_beq",    7'b1100011, 3'b000, 0, 1, 0,   1,  1,  0,  0,  0,  0, 3'b001, 2'b10, 1);
        apply("illegal_zero",  7'b0000000, 3'b000, 0, 0, 0,   0,  0,  0,  0,  0,  0, 3'b000, 2'b00, 1);
        apply("mid_reset_lw",  7'b0000011, 3'b000, 0, 0, 1,   0,  0,  1,  0,  1,  1, 3'b000, 2'b00, 1);
        apply("cleared_sw",    7'b0100011, 3'b000, 0, 0, 0,   0,  0,  0,  1,  1,  0, 3'b000, 2'b01, 0);

        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
